iob_ram_responder: RTL and testbench



---
 rtl/iob_ram_responder_pkg.sv | 11 +
 rtl/iob_sp_ram_be.sv | 21 ++
 rtl/iob_ram_responder.sv | 75 +++++++
 tb/tb_iob_ram_responder.sv | 139 +++++++++++++
 4 files changed

// File: rtl/iob_ram_responder_pkg.sv
// iob_ram_responder_pkg: iob native bus layout shared by the responder and its bench
package iob_ram_responder_pkg;
  localparam int BUS_AW = 32;
  localparam int CNT_W = 4;
  function automatic int req_w(input int dw);
    return 1 + BUS_AW + dw + dw / 8;
  endfunction
  function automatic int resp_w(input int dw);
    return dw + 1;
  endfunction
endpackage

// File: rtl/iob_sp_ram_be.sv
// iob_sp_ram_be: single-port RAM with per-byte write enables and a registered, self-clearing read port
module iob_sp_ram_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DATA_W/8-1:0] we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  output logic [DATA_W-1:0]   dout
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W / 8; i++)
      if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
  end
  // dout holds a word only for the cycle after a read; reset clears it but never the array
  always_ff @(posedge clk) dout <= (rst || !en) ? '0 : mem[addr];
endmodule

// File: rtl/iob_ram_responder.sv
// iob_ram_responder: byte-writable RAM on the iob native bus with a fixed number of wait states
module iob_ram_responder
  import iob_ram_responder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int WAIT_STATES = 1,
  localparam int REQ_W = req_w(DATA_W),
  localparam int RESP_W = resp_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  req,
  output logic [RESP_W-1:0] resp
);
  localparam int SW = DATA_W / 8;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
    $error("iob_ram_responder: WAIT_STATES must be 0..15");
  end
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_W-1:0] addr_q, req_idx, ram_addr;
  logic [DATA_W-1:0] wdata_q, req_wdata, ram_wdata, ram_dout;
  logic [SW-1:0] wstrb_q, req_wstrb, ram_wstrb;
  logic valid, idle, go_resp, ready_q, unused;
  assign valid = req[REQ_W-1];
  assign req_idx = req[SW+DATA_W+2 +: ADDR_W];
  assign req_wdata = req[SW +: DATA_W];
  assign req_wstrb = req[SW-1:0];
  // byte offset and upper address bits are don't-care: upper addresses alias onto the array
  assign unused = ^{req[REQ_W-2 : SW+DATA_W+2+ADDR_W], req[SW+DATA_W +: 2]};
  // in IDLE the RAM sees the live request so a zero-wait access lands on the accepting edge
  always_comb begin
    idle = state == IDLE;
    go_resp = !rst && (idle ? valid && WS == '0 : state == WAIT && cnt == CNT_W'(1));
    ram_addr = idle ? req_idx : addr_q;
    ram_wdata = idle ? req_wdata : wdata_q;
    ram_wstrb = idle ? req_wstrb : wstrb_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= go_resp;
      if (idle) begin
        if (valid) begin
          addr_q <= req_idx;
          wdata_q <= req_wdata;
          wstrb_q <= req_wstrb;
          cnt <= WS;
          state <= WS == '0 ? RESP : WAIT;
        end
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
        state <= cnt == CNT_W'(1) ? RESP : WAIT;
      end else begin
        state <= IDLE;
      end
    end
  end
  iob_sp_ram_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .rst(rst),
    .en(go_resp && ram_wstrb == '0),
    .we(go_resp ? ram_wstrb : '0),
    .addr(ram_addr),
    .din(ram_wdata),
    .dout(ram_dout)
  );
  assign resp = {ram_dout, ready_q};
endmodule

// File: tb/tb_iob_ram_responder.sv
// tb_iob_ram_responder: scoreboard bench driving a zero-wait and a three-wait responder against an array model
module tb_iob_ram_responder;
  import iob_ram_responder_pkg::*;
  localparam int REQ_W = req_w(32);
  localparam int RESP_W = resp_w(32);
  typedef struct {
    logic [31:0] rd;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [REQ_W-1:0] req [2];
  logic [RESP_W-1:0] resp [2];
  exp_t sb [2][$];
  logic [31:0] m [2][1024];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  iob_ram_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .resp(resp[0])
  );
  iob_ram_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst), .req(req[1]), .resp(resp[1])
  );
  function automatic int ws(input int d);
    return d == 0 ? 0 : 3;
  endfunction
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (resp[d][0] === 1'b1) begin
        tests++;
        if (sb[d].size() == 0) begin
          fails++;
          $display("FAIL unexpected_ready dut%0d cyc=%0d rdata=%h required no ready", d, cyc, resp[d][32:1]);
        end else begin
          exp_t e;
          e = sb[d].pop_front();
          if (resp[d][32:1] !== e.rd || cyc != e.cyc) begin
            fails++;
            $display("FAIL resp dut%0d got rdata=%h cyc=%0d required rdata=%h cyc=%0d",
                     d, resp[d][32:1], cyc, e.rd, e.cyc);
          end
        end
      end else begin
        tests++;
        if (resp[d] !== '0) begin
          fails++;
          $display("FAIL idle_resp dut%0d cyc=%0d got %h required 0", d, cyc, resp[d]);
        end
      end
    end
  end
  task automatic xact(input int d, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input bit hold);
    int idx, n;
    exp_t e;
    idx = int'((a >> 2) % 1024);
    e.rd = '0;
    if (st == 4'h0) e.rd = m[d][idx];
    else for (int b = 0; b < 4; b++) if (st[b]) m[d][idx][8*b +: 8] = wd[8*b +: 8];
    @(negedge clk);
    req[d] = {1'b1, a, wd, st};
    @(posedge clk);
    #1;
    e.cyc = cyc + ws(d);
    sb[d].push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      if (!hold && n >= 1) req[d][REQ_W-1] = 1'b0;
      n++;
    end while (resp[d][0] !== 1'b1 && n < 40);
    req[d] = '0;
    if (resp[d][0] !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL timeout dut%0d addr=%h got no ready required ready within 40 cycles", d, a);
    end
    @(posedge clk);
  endtask
  initial begin
    logic [31:0] a;
    logic [3:0] st;
    int d;
    req[0] = '0;
    req[1] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 64; i++) xact(k, 32'(i) << 2, $urandom, 4'hF, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    req[0] = {1'b1, 32'h14, 32'hCAFEF00D, 4'hF};
    req[1] = {1'b1, 32'h14, 32'hCAFEF00D, 4'hF};
    repeat (3) @(negedge clk);
    req[0] = '0;
    req[1] = '0;
    rst = 1'b0;
    xact(0, 32'h14, 32'h0, 4'h0, 1'b1);
    xact(1, 32'h14, 32'h0, 4'h0, 1'b1);
    xact(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    xact(0, 32'h10, 32'h0, 4'h0, 1'b1);
    xact(0, 32'h20, 32'h11223344, 4'hF, 1'b1);
    xact(0, 32'h20, 32'hAABBCCDD, 4'h5, 1'b1);
    xact(0, 32'h20, 32'h0, 4'h0, 1'b1);
    xact(0, 32'h1004, 32'h55, 4'hF, 1'b1);
    xact(0, 32'h0004, 32'h0, 4'h0, 1'b1);
    xact(1, 32'h10, 32'h12345678, 4'hF, 1'b1);
    xact(1, 32'h10, 32'h0, 4'h0, 1'b0);
    xact(1, 32'h30, 32'h0, 4'hF, 1'b1);
    @(negedge clk);
    req[1] = {1'b1, 32'h30, 32'hFFFFFFFF, 4'hF};
    @(posedge clk);
    @(negedge clk);
    req[1] = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    xact(1, 32'h30, 32'h0, 4'h0, 1'b1);
    for (int k = 0; k < 200; k++) begin
      d = int'($urandom_range(0, 1));
      a = ($urandom & 32'hFFFFF000) | ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
      st = $urandom_range(0, 1) == 0 ? 4'h0 : 4'($urandom_range(1, 15));
      xact(d, a, $urandom, st, $urandom_range(0, 1) == 1);
    end
    repeat (5) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (sb[k].size() != 0) begin
        fails++;
        $display("FAIL pending dut%0d got %0d outstanding required 0", k, sb[k].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
